// File: rtl/otn_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | otn_pkg : OTN framing constants, frame-FSM encodings and CRC-8 helper     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package otn_pkg;

   localparam logic [7:0] OTN_FAS_HI   = 8'hF6;
   localparam logic [7:0] OTN_FAS_LO   = 8'h28;
   localparam logic [7:0] OTN_ACK_CODE = 8'h06;
   localparam logic [7:0] OTN_NAK_CODE = 8'h15;

   typedef logic [2:0] rx_state_t;

   localparam rx_state_t ST_HUNT = 3'd0;
   localparam rx_state_t ST_FAS2 = 3'd1;
   localparam rx_state_t ST_PYLD = 3'd2;
   localparam rx_state_t ST_CRC  = 3'd3;
   localparam rx_state_t ST_ACK  = 3'd4;

   localparam logic [1:0] UB_IDLE  = 2'd0;
   localparam logic [1:0] UB_START = 2'd1;
   localparam logic [1:0] UB_DATA  = 2'd2;
   localparam logic [1:0] UB_STOP  = 2'd3;

   // MSB-first, unreflected CRC-8 update over one byte.
   function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in,
                                            input logic [7:0] data,
                                            input logic [7:0] poly);
      logic [7:0] c;
      c = crc_in;
      for (int i = 7; i >= 0; i--) begin
         c = (c[7] ^ data[i]) ? ({c[6:0], 1'b0} ^ poly) : {c[6:0], 1'b0};
      end
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/otn_uart_byte_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | otn_uart_byte_rx : 16x-oversampled UART byte receiver, 8N1, LSB first     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module otn_uart_byte_rx
   import otn_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_clk_en_16_x_baud,
   input  logic       i_rx,
   output logic [7:0] o_byte,
   output logic       o_byte_valid,
   output logic       o_ferr
);

   logic       sync1_q, sync1_d;
   logic       sync2_q, sync2_d;
   logic       prev_q,  prev_d;
   logic [1:0] st_q,    st_d;
   logic [3:0] tick_q,  tick_d;
   logic [2:0] bit_q,   bit_d;
   logic [7:0] sh_q,    sh_d;
   logic       valid_q, valid_d;
   logic       ferr_q,  ferr_d;

   always_comb begin
      sync1_d = i_rx;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
      st_d    = st_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (st_q)
         UB_IDLE: begin
            if (prev_q && !sync2_q) begin
               st_d   = UB_START;
               tick_d = 4'd0;
            end
         end
         UB_START: begin
            // Eighth strobe lands mid start bit; a high line here is a glitch.
            if (i_clk_en_16_x_baud) begin
               if (tick_q == 4'd7) begin
                  if (sync2_q) begin
                     st_d = UB_IDLE;
                  end else begin
                     st_d   = UB_DATA;
                     tick_d = 4'd0;
                     bit_d  = 3'd0;
                  end
               end else begin
                  tick_d = tick_q + 4'd1;
               end
            end
         end
         UB_DATA: begin
            if (i_clk_en_16_x_baud) begin
               if (tick_q == 4'd15) begin
                  sh_d   = {sync2_q, sh_q[7:1]};
                  tick_d = 4'd0;
                  if (bit_q == 3'd7) st_d = UB_STOP;
                  else               bit_d = bit_q + 3'd1;
               end else begin
                  tick_d = tick_q + 4'd1;
               end
            end
         end
         UB_STOP: begin
            if (i_clk_en_16_x_baud) begin
               if (tick_q == 4'd15) begin
                  valid_d = sync2_q;
                  ferr_d  = !sync2_q;
                  st_d    = UB_IDLE;
               end else begin
                  tick_d = tick_q + 4'd1;
               end
            end
         end
         default: st_d = UB_IDLE;
      endcase
   end

   // Synchroniser resets to the idle line level so reset release cannot fake a start.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
         st_q    <= UB_IDLE;
         tick_q  <= 4'd0;
         bit_q   <= 3'd0;
         sh_q    <= 8'd0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         st_q    <= st_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   assign o_byte       = sh_q;
   assign o_byte_valid = valid_q;
   assign o_ferr       = ferr_q;

endmodule
`default_nettype wire

// File: rtl/otn_line_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | otn_line_rx : OTN line receiver - FAS hunt, payload, CRC-8, ACK/NAK return|
// | Optional CRC comparison enabled by macro OTN_RX_CRC_CHK_EN.   Rev 1.0     |
// +--------------------------------------------------------------------------+
module otn_line_rx
   import otn_pkg::*;
#(
   parameter int         PYLD_BYTES = 16,
   parameter logic [7:0] FAS_HI     = OTN_FAS_HI,
   parameter logic [7:0] FAS_LO     = OTN_FAS_LO,
   parameter logic [7:0] CRC_POLY   = 8'h07,
   parameter logic [7:0] CRC_INIT   = 8'h00,
   parameter logic [7:0] ACK_CODE   = OTN_ACK_CODE,
   parameter logic [7:0] NAK_CODE   = OTN_NAK_CODE
)(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_clk_en_16_x_baud,
   input  logic       i_otn_rx_data,
   output logic [7:0] o_pyld_data,
   output logic       o_pyld_data_valid,
   output logic       o_frame_ok,
   output logic       o_frame_err,
   output logic [7:0] o_crc_val,
   output logic [2:0] o_rx_state,
   output logic       o_otn_tx_ack
);

   localparam logic [7:0] LAST_IDX = 8'(PYLD_BYTES - 1);

   logic [7:0] rx_byte;
   logic       rx_byte_valid;
   logic       rx_ferr;

   otn_uart_byte_rx u_byte_rx (
      .i_clk              (i_clk),
      .i_rst              (i_rst),
      .i_clk_en_16_x_baud (i_clk_en_16_x_baud),
      .i_rx               (i_otn_rx_data),
      .o_byte             (rx_byte),
      .o_byte_valid       (rx_byte_valid),
      .o_ferr             (rx_ferr)
   );

   rx_state_t  state_q,      state_d;
   logic [7:0] cnt_q,        cnt_d;
   logic [7:0] crc_q,        crc_d;
   logic [7:0] pyld_data_q,  pyld_data_d;
   logic       pyld_valid_q, pyld_valid_d;
   logic       frame_ok_q,   frame_ok_d;
   logic       frame_err_q,  frame_err_d;
   logic [7:0] crc_val_q,    crc_val_d;
   logic       tx_q,         tx_d;
   logic [9:0] tx_sh_q,      tx_sh_d;
   logic [3:0] tx_tick_q,    tx_tick_d;
   logic [3:0] tx_bit_q,     tx_bit_d;
   logic       tx_busy_q,    tx_busy_d;
   logic       enter_ack;
   logic       ack_sel;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      crc_d        = crc_q;
      pyld_data_d  = pyld_data_q;
      pyld_valid_d = 1'b0;
      frame_ok_d   = 1'b0;
      frame_err_d  = 1'b0;
      crc_val_d    = crc_val_q;
      tx_d         = tx_q;
      tx_sh_d      = tx_sh_q;
      tx_tick_d    = tx_tick_q;
      tx_bit_d     = tx_bit_q;
      tx_busy_d    = tx_busy_q;
      enter_ack    = 1'b0;
      ack_sel      = 1'b0;
      case (state_q)
         ST_HUNT: begin
            if (rx_byte_valid && rx_byte == FAS_HI) state_d = ST_FAS2;
         end
         ST_FAS2: begin
            if (rx_byte_valid) begin
               if (rx_byte == FAS_LO) begin
                  state_d = ST_PYLD;
                  crc_d   = CRC_INIT;
                  cnt_d   = 8'd0;
               end else if (rx_byte != FAS_HI) begin
                  state_d = ST_HUNT;
               end
            end
         end
         ST_PYLD: begin
            if (rx_byte_valid) begin
               pyld_data_d  = rx_byte;
               pyld_valid_d = 1'b1;
               crc_d        = crc8_byte(crc_q, rx_byte, CRC_POLY);
               cnt_d        = cnt_q + 8'd1;
               if (cnt_q == LAST_IDX) state_d = ST_CRC;
            end else if (rx_ferr) begin
               frame_err_d = 1'b1;
               enter_ack   = 1'b1;
            end
         end
         ST_CRC: begin
            if (rx_byte_valid) begin
               crc_val_d = crc_q;
               enter_ack = 1'b1;
`ifdef OTN_RX_CRC_CHK_EN
               if (rx_byte == crc_q) begin
                  frame_ok_d = 1'b1;
                  ack_sel    = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
               end
`else
               frame_ok_d = 1'b1;
               ack_sel    = 1'b1;
`endif
            end else if (rx_ferr) begin
               frame_err_d = 1'b1;
               enter_ack   = 1'b1;
            end
         end
         ST_ACK: begin
            // First strobe after entry drives the start bit; each bit lasts 16 strobes.
            if (i_clk_en_16_x_baud) begin
               if (!tx_busy_q) begin
                  tx_busy_d = 1'b1;
                  tx_d      = tx_sh_q[0];
                  tx_tick_d = 4'd0;
               end else if (tx_tick_q == 4'd15) begin
                  tx_tick_d = 4'd0;
                  if (tx_bit_q == 4'd9) begin
                     tx_d      = 1'b1;
                     tx_busy_d = 1'b0;
                     state_d   = ST_HUNT;
                  end else begin
                     tx_bit_d = tx_bit_q + 4'd1;
                     tx_sh_d  = {1'b1, tx_sh_q[9:1]};
                     tx_d     = tx_sh_q[1];
                  end
               end else begin
                  tx_tick_d = tx_tick_q + 4'd1;
               end
            end
         end
         default: state_d = ST_HUNT;
      endcase

      if (enter_ack) begin
         state_d   = ST_ACK;
         tx_sh_d   = {1'b1, (ack_sel ? ACK_CODE : NAK_CODE), 1'b0};
         tx_tick_d = 4'd0;
         tx_bit_d  = 4'd0;
         tx_busy_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= ST_HUNT;
         cnt_q        <= 8'd0;
         crc_q        <= 8'd0;
         pyld_data_q  <= 8'd0;
         pyld_valid_q <= 1'b0;
         frame_ok_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         crc_val_q    <= 8'd0;
         tx_q         <= 1'b1;
         tx_sh_q      <= 10'd0;
         tx_tick_q    <= 4'd0;
         tx_bit_q     <= 4'd0;
         tx_busy_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         crc_q        <= crc_d;
         pyld_data_q  <= pyld_data_d;
         pyld_valid_q <= pyld_valid_d;
         frame_ok_q   <= frame_ok_d;
         frame_err_q  <= frame_err_d;
         crc_val_q    <= crc_val_d;
         tx_q         <= tx_d;
         tx_sh_q      <= tx_sh_d;
         tx_tick_q    <= tx_tick_d;
         tx_bit_q     <= tx_bit_d;
         tx_busy_q    <= tx_busy_d;
      end
   end

   assign o_pyld_data       = pyld_data_q;
   assign o_pyld_data_valid = pyld_valid_q;
   assign o_frame_ok        = frame_ok_q;
   assign o_frame_err       = frame_err_q;
   assign o_crc_val         = crc_val_q;
   assign o_rx_state        = state_q;
   assign o_otn_tx_ack      = tx_q;

endmodule
`default_nettype wire
